// File: rtl/post_adder.sv
// GF(2) post-adder: captures multiplier products, XOR-accumulates them serially into the
// result block under a coefficient mask, then offers the block on a valid/ready write port.
module post_adder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned MUL_NUM = 47,
  parameter int unsigned OUT_NUM = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mul_vld_in,
  input  logic [ADDR_W-1:0]           rd_in,
  input  logic [MUL_NUM*DATA_W-1:0]   mul_data_in,
  input  logic [OUT_NUM*MUL_NUM-1:0]  coef_mask,
  output logic                        wr_vld,
  input  logic                        wr_rdy,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [OUT_NUM*DATA_W-1:0]   wr_data,
  output logic                        busy,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int unsigned JW = $clog2(MUL_NUM + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e                      state_q, state_d;
  logic [JW-1:0]               j_q, j_d;
  logic [MUL_NUM*DATA_W-1:0]   h_q, h_d;
  logic [OUT_NUM*DATA_W-1:0]   c_q, c_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic                        ovf_q, ovf_d;
  logic [JW-1:0]               j_idx;
  logic [DATA_W-1:0]           h_sel;

  // j counts 1..MUL_NUM; j_idx is the zero-based product index for the current step
  assign j_idx = (j_q == '0) ? '0 : j_q - JW'(1);
  assign h_sel = h_q[int'(j_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    h_d     = h_q;
    c_d     = c_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (mul_vld_in) begin
          h_d     = mul_data_in;
          addr_d  = rd_in;
          c_d     = '0;
          j_d     = JW'(1);
          state_d = StAcc;
        end
      end
      StAcc: begin
        for (int k = 0; k < OUT_NUM; k++) begin
          if (coef_mask[k*MUL_NUM + int'(j_idx)]) begin
            c_d[k*DATA_W +: DATA_W] = c_q[k*DATA_W +: DATA_W] ^ h_sel;
          end
        end
        j_d = j_q + JW'(1);
        if (j_q == JW'(MUL_NUM)) begin
          j_d     = '0;
          state_d = StOut;
        end
      end
      StOut: begin
        if (wr_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A pulse arriving while not idle is dropped; setting beats a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (mul_vld_in && (state_q != StIdle)) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      j_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      h_q     <= h_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_vld  = (state_q == StOut);
  assign wr_addr = addr_q;
  assign wr_data = c_q;
  assign busy    = (state_q != StIdle);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_post_adder.sv
// Self-checking bench for post_adder: directed scenarios plus randomized blocks compared
// against a plain-arithmetic GF(2) reference model.
module tb_post_adder;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MN = 47;
  localparam int ON = 16;
  localparam int LATENCY = MN + 1;

  logic               clk;
  logic               rst_n;
  logic               mul_vld_in;
  logic [AW-1:0]      rd_in;
  logic [MN*DW-1:0]   mul_data_in;
  logic [ON*MN-1:0]   coef_mask;
  logic               wr_vld;
  logic               wr_rdy;
  logic [AW-1:0]      wr_addr;
  logic [ON*DW-1:0]   wr_data;
  logic               busy;
  logic               ovf;
  logic               ovf_clr;

  int total = 0;
  int bad   = 0;
  logic exp_ovf = 1'b0;

  post_adder #(.DATA_W(DW), .ADDR_W(AW), .MUL_NUM(MN), .OUT_NUM(ON)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mul_vld_in  (mul_vld_in),
    .rd_in       (rd_in),
    .mul_data_in (mul_data_in),
    .coef_mask   (coef_mask),
    .wr_vld      (wr_vld),
    .wr_rdy      (wr_rdy),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // C_k is the XOR of every h_j whose mask bit (k,j) is set
  function automatic logic [ON*DW-1:0] model(input logic [MN*DW-1:0] h,
                                             input logic [ON*MN-1:0] m);
    logic [ON*DW-1:0] r;
    r = '0;
    for (int k = 1; k <= ON; k++)
      for (int j = 1; j <= MN; j++)
        if (m[(k-1)*MN + (j-1)]) r[k*DW-1 -: DW] = r[k*DW-1 -: DW] ^ h[j*DW-1 -: DW];
    return r;
  endfunction

  // One block: pulse, wait for wr_vld, stall 'hold' cycles, handshake.
  // extra_pulse drops pulses during the stall window and the handshake cycle.
  task automatic run_op(input logic [MN*DW-1:0] h, input logic [ON*MN-1:0] m,
                        input logic [AW-1:0] rd, input int hold, input bit extra_pulse,
                        output logic [ON*DW-1:0] got);
    logic [ON*DW-1:0] exp;
    int n;
    exp = model(h, m);
    mul_vld_in  = 1'b1;
    mul_data_in = h;
    coef_mask   = m;
    rd_in       = rd;
    wr_rdy      = (hold == 0);
    step();
    mul_vld_in  = 1'b0;
    mul_data_in = '0;
    check("busy_acc", 512'(busy), 512'(1));
    n = 1;
    while (!wr_vld && n < 100) begin
      step();
      n++;
    end
    check("latency", 512'(n), 512'(LATENCY));
    check("wr_data", 512'(wr_data), 512'(exp));
    check("wr_addr", 512'(wr_addr), 512'(rd));
    for (int i = 0; i < hold; i++) begin
      if (extra_pulse && i >= 1) begin
        mul_vld_in = 1'b1;
        exp_ovf    = 1'b1;
      end
      if (extra_pulse && i == 2) ovf_clr = 1'b1;
      step();
      mul_vld_in = 1'b0;
      ovf_clr    = 1'b0;
      check("stall_vld", 512'(wr_vld), 512'(1));
      check("stall_data", 512'(wr_data), 512'(exp));
      check("stall_addr", 512'(wr_addr), 512'(rd));
      if (extra_pulse && i >= 2) check("ovf_set_wins", 512'(ovf), 512'(1));
    end
    wr_rdy = 1'b1;
    if (extra_pulse) begin
      mul_vld_in = 1'b1;
      exp_ovf    = 1'b1;
    end
    step();
    mul_vld_in = 1'b0;
    got = wr_data;
    check("vld_fall", 512'(wr_vld), 512'(0));
    check("busy_done", 512'(busy), 512'(0));
    check("ovf", 512'(ovf), 512'(exp_ovf));
    check("data_hold", 512'(wr_data), 512'(exp));
    check("addr_hold", 512'(wr_addr), 512'(rd));
    if (extra_pulse) begin
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      check("ovf_clr", 512'(ovf), 512'(0));
    end
  endtask

  logic [MN*DW-1:0] h_s2;
  logic [ON*MN-1:0] m_s2;
  logic [ON*DW-1:0] c_s2;

  initial begin
    logic [MN*DW-1:0] h;
    logic [ON*MN-1:0] m;
    logic [ON*DW-1:0] got;
    bit saw_vld;

    rst_n = 1'b0; mul_vld_in = 1'b0; rd_in = '0; mul_data_in = '0;
    coef_mask = '0; wr_rdy = 1'b0; ovf_clr = 1'b0;
    #12;
    check("rst_vld", 512'(wr_vld), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_data", 512'(wr_data), 512'(0));
    rst_n = 1'b1;
    step();

    // Diagonal selection: C_k = h_k = k
    h_s2 = '0; m_s2 = '0; c_s2 = '0;
    for (int k = 1; k <= MN; k++) h_s2[k*DW-1 -: DW] = DW'(k);
    for (int k = 1; k <= ON; k++) begin
      m_s2[(k-1)*MN + (k-1)] = 1'b1;
      c_s2[k*DW-1 -: DW] = DW'(k);
    end
    run_op(h_s2, m_s2, 5'd5, 0, 1'b0, got);
    check("s2_result", 512'(got), 512'(c_s2));

    // XOR cancellation and empty row
    h = '0; m = '0;
    for (int j = 1; j <= MN; j++) h[j*DW-1 -: DW] = $urandom();
    h[DW-1:0] = 32'hF0; h[2*DW-1 -: DW] = 32'h0F; h[3*DW-1 -: DW] = 32'hFF;
    m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1;
    run_op(h, m, 5'd3, 0, 1'b0, got);
    check("s3_c1", 512'(got[DW-1:0]), 512'(0));
    check("s3_c3", 512'(got[3*DW-1 -: DW]), 512'(0));

    // Row 2 selects all 47 ones -> odd count gives 1
    h = '0; m = '0;
    for (int j = 1; j <= MN; j++) h[j*DW-1 -: DW] = 32'h1;
    for (int j = 0; j < MN; j++) m[MN + j] = 1'b1;
    run_op(h, m, 5'd7, 0, 1'b0, got);
    check("s3_c2", 512'(got[2*DW-1 -: DW]), 512'(1));

    // Backpressure with dropped pulses, then back-to-back at rd=9
    for (int j = 1; j <= MN; j++) h[j*DW-1 -: DW] = $urandom();
    for (int b = 0; b < ON*MN; b++) m[b] = 1'($urandom_range(0, 1));
    run_op(h, m, 5'd12, 5, 1'b1, got);
    run_op(h_s2, m_s2, 5'd1, 0, 1'b0, got);
    for (int j = 1; j <= MN; j++) h[j*DW-1 -: DW] = $urandom();
    run_op(h, m, 5'd9, 0, 1'b0, got);

    // Reset during accumulation at j=20 with a dropped pulse pending in ovf
    mul_vld_in = 1'b1; mul_data_in = h_s2; coef_mask = m_s2; rd_in = 5'd5; wr_rdy = 1'b1;
    step();
    mul_vld_in = 1'b0;
    for (int n = 1; n < 20; n++) begin
      if (n == 10) mul_vld_in = 1'b1;
      step();
      mul_vld_in = 1'b0;
    end
    check("pre_rst_ovf", 512'(ovf), 512'(1));
    rst_n = 1'b0;
    step();
    check("mid_rst_vld", 512'(wr_vld), 512'(0));
    check("mid_rst_busy", 512'(busy), 512'(0));
    check("mid_rst_ovf", 512'(ovf), 512'(0));
    check("mid_rst_data", 512'(wr_data), 512'(0));
    check("mid_rst_addr", 512'(wr_addr), 512'(0));
    rst_n = 1'b1;
    saw_vld = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (wr_vld) saw_vld = 1'b1;
    end
    check("no_write_after_rst", 512'(saw_vld), 512'(0));
    run_op(h_s2, m_s2, 5'd5, 0, 1'b0, got);
    check("s6_result", 512'(got), 512'(c_s2));

    // Randomized blocks
    for (int t = 0; t < 8; t++) begin
      for (int j = 1; j <= MN; j++) h[j*DW-1 -: DW] = $urandom();
      for (int b = 0; b < ON*MN; b++) m[b] = 1'($urandom_range(0, 1));
      run_op(h, m, AW'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
